// File: rtl/simple_pkg.sv
// -----------------------------------------------------------------------------
// simple_pkg
// Shared constants and types for the SIMPLE pipeline register file slice.
//   DATA_WIDTH : register / result width
//   REG_COUNT  : number of architectural registers
//   ADDR_WIDTH : register index width
//   PEND_WIDTH : width of each per-register in-flight write counter
// -----------------------------------------------------------------------------
package simple_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int REG_COUNT  = 8;
  localparam int ADDR_WIDTH = 3;
  localparam int PEND_WIDTH = 2;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [PEND_WIDTH-1:0] pend_t;

  // Saturation point of a pending counter (3 outstanding writes).
  localparam pend_t PEND_MAX = '1;

endpackage

// File: rtl/p5_scoreboard.sv
// -----------------------------------------------------------------------------
// p5_scoreboard
// Per-register count of register writes issued by decode but not yet
// committed by writeback. Drives the RAW hazard flags for the two decode
// read ports and a sticky error flag for counter overflow/underflow.
//
// Ports:
//   clock, reset_n            : clock, asynchronous active-low reset
//   issueValid, issueAddr     : decode issued a write to issueAddr (+1)
//   commitValid, commitAddr   : writeback commits to commitAddr (-1)
//   readAddrA, readAddrB      : decode source register indices
//   hazardA, hazardB          : source has an uncommitted, un-bypassed write
//   scoreErr                  : sticky overflow/underflow, cleared by reset
//
// Issue and commit are single-cycle pulses qualified by their valid bit;
// there is no ready/backpressure, every valid pulse is consumed on the edge.
// -----------------------------------------------------------------------------
module p5_scoreboard
  import simple_pkg::*;
(
  input  logic      clock,
  input  logic      reset_n,
  input  logic      issueValid,
  input  reg_addr_t issueAddr,
  input  logic      commitValid,
  input  reg_addr_t commitAddr,
  input  reg_addr_t readAddrA,
  input  reg_addr_t readAddrB,
  output logic      hazardA,
  output logic      hazardB,
  output logic      scoreErr
);

  pend_t pending [REG_COUNT];

  // One-hot increment / decrement selects per register.
  logic [REG_COUNT-1:0] incHit;
  logic [REG_COUNT-1:0] decHit;

  always_comb begin
    incHit = '0;
    decHit = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      incHit[i] = issueValid  && (issueAddr  == reg_addr_t'(i));
      decHit[i] = commitValid && (commitAddr == reg_addr_t'(i));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        pending[i] <= '0;
      end
      scoreErr <= 1'b0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        // Issue and commit on the same register cancel out.
        if (incHit[i] && !decHit[i]) begin
          if (pending[i] == PEND_MAX) begin
            scoreErr <= 1'b1;
          end else begin
            pending[i] <= pending[i] + pend_t'(1);
          end
        end else if (decHit[i] && !incHit[i]) begin
          if (pending[i] == '0) begin
            scoreErr <= 1'b1;
          end else begin
            pending[i] <= pending[i] - pend_t'(1);
          end
        end
      end
    end
  end

  // A register whose last outstanding write commits this cycle is served by
  // the bypass path, so it must not stall decode.
  always_comb begin
    hazardA = (pending[readAddrA] != '0) &&
              !(commitValid && (commitAddr == readAddrA) &&
                (pending[readAddrA] == pend_t'(1)));
    hazardB = (pending[readAddrB] != '0) &&
              !(commitValid && (commitAddr == readAddrB) &&
                (pending[readAddrB] == pend_t'(1)));
  end

endmodule

// File: rtl/p5_writeback.sv
// -----------------------------------------------------------------------------
// p5_writeback
// Writeback stage of the SIMPLE pipeline. Commits p4 results into an 8x16
// register file, serves two combinational decode read ports with same-cycle
// write bypass, and tracks in-flight writes for RAW hazard detection.
//
// Ports:
//   clock, reset_n               : clock, asynchronous active-low reset
//   writeRegp4, regAddressp4,
//   writeDatap4                  : commit request from the memory stage
//   issueValid, issueAddr        : decode issued a register-writing instr
//   readAddrA/B, readDataA/B     : decode read ports (combinational, bypassed)
//   hazardA/B                    : pending-write hazard per read port
//   commitCount                  : commits since reset, wraps at 16 bits
//   scoreErr                     : sticky scoreboard overflow/underflow
//
// writeRegp4 is a valid-only strobe: p4 changes its outputs on negedge, so
// they are stable at the following posedge, and a commit always completes.
// -----------------------------------------------------------------------------
module p5_writeback
  import simple_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        writeRegp4,
  input  reg_addr_t   regAddressp4,
  input  word_t       writeDatap4,
  input  logic        issueValid,
  input  reg_addr_t   issueAddr,
  input  reg_addr_t   readAddrA,
  input  reg_addr_t   readAddrB,
  output word_t       readDataA,
  output word_t       readDataB,
  output logic        hazardA,
  output logic        hazardB,
  output logic [15:0] commitCount,
  output logic        scoreErr
);

  word_t regFile [REG_COUNT];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regFile[i] <= '0;
      end
      commitCount <= '0;
    end else if (writeRegp4) begin
      regFile[regAddressp4] <= writeDatap4;
      commitCount           <= commitCount + 16'd1;
    end
  end

  // Same-cycle bypass so decode sees a result in the cycle it commits.
  always_comb begin
    readDataA = regFile[readAddrA];
    readDataB = regFile[readAddrB];
    if (writeRegp4 && (regAddressp4 == readAddrA)) begin
      readDataA = writeDatap4;
    end
    if (writeRegp4 && (regAddressp4 == readAddrB)) begin
      readDataB = writeDatap4;
    end
  end

  p5_scoreboard u_scoreboard (
    .clock       (clock),
    .reset_n     (reset_n),
    .issueValid  (issueValid),
    .issueAddr   (issueAddr),
    .commitValid (writeRegp4),
    .commitAddr  (regAddressp4),
    .readAddrA   (readAddrA),
    .readAddrB   (readAddrB),
    .hazardA     (hazardA),
    .hazardB     (hazardB),
    .scoreErr    (scoreErr)
  );

endmodule

// File: tb/tb_p5_writeback.sv
// -----------------------------------------------------------------------------
// tb_p5_writeback
// Directed bench for p5_writeback. Inputs change just after negedge, outputs
// are sampled 1ns later (well before the next posedge).
// -----------------------------------------------------------------------------
module tb_p5_writeback;
  import simple_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        writeRegp4;
  reg_addr_t   regAddressp4;
  word_t       writeDatap4;
  logic        issueValid;
  reg_addr_t   issueAddr;
  reg_addr_t   readAddrA;
  reg_addr_t   readAddrB;
  word_t       readDataA;
  word_t       readDataB;
  logic        hazardA;
  logic        hazardB;
  logic [15:0] commitCount;
  logic        scoreErr;

  int checks   = 0;
  int failures = 0;

  p5_writeback dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .writeRegp4   (writeRegp4),
    .regAddressp4 (regAddressp4),
    .writeDatap4  (writeDatap4),
    .issueValid   (issueValid),
    .issueAddr    (issueAddr),
    .readAddrA    (readAddrA),
    .readAddrB    (readAddrB),
    .readDataA    (readDataA),
    .readDataB    (readDataB),
    .hazardA      (hazardA),
    .hazardB      (hazardB),
    .commitCount  (commitCount),
    .scoreErr     (scoreErr)
  );

  // ---------------- clock ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic drive(input logic wr, input reg_addr_t wa, input word_t wd,
                       input logic iv, input reg_addr_t ia);
    writeRegp4   = wr;
    regAddressp4 = wa;
    writeDatap4  = wd;
    issueValid   = iv;
    issueAddr    = ia;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0);
  endtask

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n   = 1'b0;
    readAddrA = 3'd0;
    readAddrB = 3'd0;
    idle();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // 1. reset state on both read ports
    for (int i = 0; i < REG_COUNT; i++) begin
      readAddrA = reg_addr_t'(i);
      readAddrB = reg_addr_t'(REG_COUNT - 1 - i);
      #1;
      check_eq("rst_rdA", readDataA, 16'h0000);
      check_eq("rst_rdB", readDataB, 16'h0000);
      check_eq("rst_hzA", {15'd0, hazardA}, 16'd0);
      check_eq("rst_hzB", {15'd0, hazardB}, 16'd0);
      tick();
    end
    check_eq("rst_cnt", commitCount, 16'd0);
    check_eq("rst_err", {15'd0, scoreErr}, 16'd0);

    // 2. bypass on r3 (issued first so no underflow)
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd3);
    tick();
    drive(1'b1, 3'd3, 16'hBEEF, 1'b0, 3'd0);
    readAddrA = 3'd3;
    readAddrB = 3'd2;
    #1;
    check_eq("byp_rdA", readDataA, 16'hBEEF);
    check_eq("byp_rdB", readDataB, 16'h0000);
    check_eq("byp_hzA", {15'd0, hazardA}, 16'd0);
    tick();
    idle();
    #1;
    check_eq("arr_rdA", readDataA, 16'hBEEF);
    check_eq("arr_cnt", commitCount, 16'd1);
    check_eq("arr_err", {15'd0, scoreErr}, 16'd0);

    // 3. two issues to r5, then two commits
    readAddrA = 3'd5;
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
    tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd5);
    #1;
    check_eq("r5_p1_hz", {15'd0, hazardA}, 16'd1);
    tick();
    idle();
    #1;
    check_eq("r5_p2_hz", {15'd0, hazardA}, 16'd1);
    drive(1'b1, 3'd5, 16'h1111, 1'b0, 3'd0);
    #1;
    check_eq("r5_c1_hz", {15'd0, hazardA}, 16'd1);
    check_eq("r5_c1_rd", readDataA, 16'h1111);
    tick();
    drive(1'b1, 3'd5, 16'h2222, 1'b0, 3'd0);
    #1;
    check_eq("r5_c2_hz", {15'd0, hazardA}, 16'd0);
    check_eq("r5_c2_rd", readDataA, 16'h2222);
    tick();
    idle();
    #1;
    check_eq("r5_done_hz", {15'd0, hazardA}, 16'd0);
    check_eq("r5_done_rd", readDataA, 16'h2222);
    check_eq("r5_cnt", commitCount, 16'd3);

    // 4. simultaneous issue/commit
    readAddrA = 3'd2;
    readAddrB = 3'd6;
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd2);
    tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd6);
    tick();
    drive(1'b1, 3'd2, 16'h0202, 1'b1, 3'd2);
    #1;
    check_eq("same_hz_now", {15'd0, hazardA}, 16'd0);
    check_eq("same_rd_now", readDataA, 16'h0202);
    tick();
    idle();
    #1;
    check_eq("same_hz_after", {15'd0, hazardA}, 16'd1);
    check_eq("r6_hz_pend", {15'd0, hazardB}, 16'd1);
    drive(1'b1, 3'd6, 16'h0606, 1'b1, 3'd2);
    #1;
    check_eq("diff_hzB_now", {15'd0, hazardB}, 16'd0);
    check_eq("diff_rdB_now", readDataB, 16'h0606);
    tick();
    idle();
    #1;
    check_eq("diff_hzA", {15'd0, hazardA}, 16'd1);
    check_eq("diff_hzB", {15'd0, hazardB}, 16'd0);
    check_eq("diff_err", {15'd0, scoreErr}, 16'd0);
    drive(1'b1, 3'd2, 16'h2A2A, 1'b0, 3'd0);
    #1;
    check_eq("r2_p2_hz", {15'd0, hazardA}, 16'd1);
    tick();
    drive(1'b1, 3'd2, 16'h2B2B, 1'b0, 3'd0);
    #1;
    check_eq("r2_last_hz", {15'd0, hazardA}, 16'd0);
    tick();
    idle();
    #1;
    check_eq("r2_rd", readDataA, 16'h2B2B);
    check_eq("r2_cnt", commitCount, 16'd7);

    // 5a. overflow: four issues to r1
    readAddrA = 3'd1;
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd1);
      #1;
      if (k == 3) check_eq("ovf_err_pre", {15'd0, scoreErr}, 16'd0);
      tick();
    end
    idle();
    #1;
    check_eq("ovf_err", {15'd0, scoreErr}, 16'd1);
    check_eq("ovf_hz", {15'd0, hazardA}, 16'd1);
    // Saturated at 3: three commits drain it.
    drive(1'b1, 3'd1, 16'h0101, 1'b0, 3'd0);
    tick();
    drive(1'b1, 3'd1, 16'h0102, 1'b0, 3'd0);
    #1;
    check_eq("sat_c2_hz", {15'd0, hazardA}, 16'd1);
    tick();
    drive(1'b1, 3'd1, 16'h0103, 1'b0, 3'd0);
    #1;
    check_eq("sat_c3_hz", {15'd0, hazardA}, 16'd0);
    tick();
    idle();
    #1;
    check_eq("sat_drained_hz", {15'd0, hazardA}, 16'd0);
    check_eq("sat_rd", readDataA, 16'h0103);
    check_eq("sat_err_sticky", {15'd0, scoreErr}, 16'd1);
    check_eq("sat_cnt", commitCount, 16'd10);

    // 5b. reset clears error
    reset_n = 1'b0;
    #1;
    check_eq("rst2_err", {15'd0, scoreErr}, 16'd0);
    check_eq("rst2_cnt", commitCount, 16'd0);
    check_eq("rst2_rd", readDataA, 16'h0000);
    @(negedge clock);
    reset_n = 1'b1;

    // 5c. underflow: commit to r4 with nothing pending
    readAddrA = 3'd4;
    drive(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0);
    #1;
    check_eq("unf_byp", readDataA, 16'h4444);
    check_eq("unf_hz", {15'd0, hazardA}, 16'd0);
    tick();
    idle();
    #1;
    check_eq("unf_err", {15'd0, scoreErr}, 16'd1);
    check_eq("unf_rd", readDataA, 16'h4444);
    check_eq("unf_cnt", commitCount, 16'd1);

    // 6. async reset mid-cycle with r7=0x1234, pending[7]=2
    readAddrA = 3'd7;
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7);
    tick();
    drive(1'b1, 3'd7, 16'h1234, 1'b1, 3'd7);
    tick();
    drive(1'b0, 3'd0, 16'h0000, 1'b1, 3'd7);
    tick();
    idle();
    #1;
    check_eq("pre_ar_rd", readDataA, 16'h1234);
    check_eq("pre_ar_hz", {15'd0, hazardA}, 16'd1);
    check_eq("pre_ar_cnt", commitCount, 16'd2);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("ar_rd", readDataA, 16'h0000);
    check_eq("ar_hz", {15'd0, hazardA}, 16'd0);
    check_eq("ar_cnt", commitCount, 16'd0);
    check_eq("ar_err", {15'd0, scoreErr}, 16'd0);
    @(negedge clock);
    reset_n   = 1'b1;
    readAddrA = 3'd0;
    readAddrB = 3'd7;
    drive(1'b1, 3'd0, 16'h00AA, 1'b1, 3'd0);
    tick();
    idle();
    #1;
    check_eq("post_rdA", readDataA, 16'h00AA);
    check_eq("post_rdB", readDataB, 16'h0000);
    check_eq("post_cnt", commitCount, 16'd1);
    check_eq("post_err", {15'd0, scoreErr}, 16'd0);
    check_eq("post_hz", {15'd0, hazardA}, 16'd0);

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/p5_writeback.md
Name: p5_writeback

Overview:
- Writeback stage of the SIMPLE pipeline.
- Consumes the p4 memory-stage outputs (write enable, destination register, result data) and commits them into an 8x16 register file.
- Serves the decode stage: two combinational read ports with same-cycle write bypass.
- Holds a per-register pending-write scoreboard so decode can detect RAW hazards on results still in flight.

Parameters:
- DATA_WIDTH, 16, register and result width
- REG_COUNT, 8, number of architectural registers
- ADDR_WIDTH, 3, register index width (log2 REG_COUNT)
- PEND_WIDTH, 2, width of each per-register in-flight counter (max 3 outstanding)

Ports:
- clock  in  1  single system clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- writeRegp4  in  1  commit request from p4 (WriteRegp4)
- regAddressp4  in  ADDR_WIDTH  destination register from p4 (RegAddressp4)
- writeDatap4  in  DATA_WIDTH  result from p4 (readOutData)
- issueValid  in  1  decode issues an instruction that writes a register
- issueAddr  in  ADDR_WIDTH  destination of the issued instruction
- readAddrA  in  ADDR_WIDTH  decode read port A index
- readAddrB  in  ADDR_WIDTH  decode read port B index
- readDataA  out  DATA_WIDTH  port A data (combinational)
- readDataB  out  DATA_WIDTH  port B data (combinational)
- hazardA  out  1  port A register has an uncommitted write pending
- hazardB  out  1  port B register has an uncommitted write pending
- commitCount  out  16  number of commits since reset, wraps
- scoreErr  out  1  sticky: scoreboard overflow or underflow

Behaviour:
- Reset (reset_n=0, asynchronous):
  - all registers = 0; all pending counters = 0; commitCount = 0; scoreErr = 0.
  - Reset is honoured mid-operation: an in-progress commit or issue is discarded.
- Commit:
  - Fires on posedge when writeRegp4=1: reg[regAddressp4] <= writeDatap4; commitCount <= commitCount+1 (wraps 0xFFFF -> 0).
  - Latency 1 cycle into the array.
  - The p4 outputs change on negedge, so they are stable by the next posedge; no retiming is done here.
- Read ports:
  - readDataX = reg[readAddrX], except when writeRegp4=1 and regAddressp4==readAddrX; then readDataX = writeDatap4 (bypass).
  - Both ports bypass independently; A and B may use the same index.
- Scoreboard (per register, PEND_WIDTH-bit counter):
  - issueValid only: pending[issueAddr] +1.
  - commit only: pending[regAddressp4] -1.
  - Both on the same register in the same cycle: counter unchanged.
  - Both on different registers: each is updated independently.
  - Overflow: increment at 3 -> counter stays 3; scoreErr <= 1.
  - Underflow: decrement at 0 -> counter stays 0; scoreErr <= 1. This covers commits with no matching issue.
  - scoreErr clears only on reset.
- Hazard outputs (combinational):
  - hazardX = (pending[readAddrX] != 0) AND NOT (writeRegp4 AND regAddressp4==readAddrX AND pending[readAddrX]==1).
  - A final commit this cycle is bypassed, so it does not stall.
  - hazardX ignores issueValid in the same cycle; decode never reads its own destination as a source hazard.
- No state machine beyond the counters. All outputs are defined every cycle. There are no X-propagation paths from unwritten registers after reset.

Decomposition:
- Shared package simple_pkg:
  - DATA_WIDTH, REG_COUNT, ADDR_WIDTH constants
  - reg_addr_t (3-bit) and word_t (16-bit) typedefs
- One natural sub-module: p5_scoreboard. It holds the pending counter array with sat-inc/sat-dec, the error flag and the hazard logic.
- The register file and bypass stay in p5_writeback.

Test Plan:
1. Reset, then read all 8 registers on A and B -> all 0x0000; hazardA=hazardB=0; commitCount=0; scoreErr=0.
2. Bypass: writeRegp4=1, regAddressp4=3, writeDatap4=0xBEEF, readAddrA=3 in the same cycle -> readDataA=0xBEEF before the edge. The next cycle, with writeRegp4=0 -> readDataA=0xBEEF from the array; commitCount=1.
3. Scoreboard hazard, driven on successive cycles:
   - issueValid with issueAddr=5, twice, on separate cycles -> hazardA=1 for readAddrA=5.
   - First commit to r5 -> hazardA still 1.
   - Second commit to r5 in the same cycle it is read -> hazardA=0, with bypassed data.
   - After the edge -> counter 0, hazardA=0.
4. Simultaneous issue and commit on r2, with pending[2]=1 -> pending stays 1 and hazard for r2 stays asserted. Same case on r2 (issue) and r6 (commit) -> pending[2]=2, pending[6]=0.
5. Errors:
   - Four issues to r1 with no commits -> counter saturates at 3; scoreErr=1.
   - Reset -> scoreErr=0.
   - Commit to r4 with pending 0 -> scoreErr=1; r4 is still written with the data.
6. Async reset mid-stream: drop reset_n between edges while r7=0x1234 and pending[7]=2 -> immediately readDataA(r7)=0, hazard=0, commitCount=0. Commits resume normally after reset_n rises.
